sfp_mult_arb: RTL

- Shares one pipelined full-precision sfp multiplier among N requesters.
- Each requester offers an operand pair over a valid/ready handshake. A round-robin arbiter grants one pair per cycle.
- The product leaves on a single tagged output stream with valid/ready backpressure.
- Sits between parallel DSP lanes (filter taps, gain stages) and the one physical multiplier we can afford per lane group.

---
 rtl/fp_sched_pkg.sv | 28 ++
 rtl/sfp_mult_full.sv | 33 +++
 rtl/sfp_rr_arbiter.sv | 31 +++
 rtl/sfp_mult_arb.sv | 124 ++++++++++++
 4 files changed

// File: rtl/fp_sched_pkg.sv
// Shared helpers for the sfp multiply/add schedulers: id sizing and the
// round-robin grant search used by every arbiter in the group.
package fp_sched_pkg;

  localparam int MAX_LAT = 4;
  localparam int MAX_N   = 16;

  function automatic int id_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // First requesting index at or after ptr, wrapping modulo n; 0 when idle.
  function automatic int rr_next(input logic [3:0] ptr, input logic [15:0] req, input int n);
    int idx;
    int res;
    res = 0;
    for (int k = MAX_N - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (int'(ptr) + k) % n;
        if (req[4'(idx)]) res = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sfp_mult_full.sv
// Full-precision signed fixed-point multiply: integer and fraction widths add,
// no rounding and no saturation, so the product can never overflow.
module sfp_mult_full #(
  parameter int IW1    = 4,
  parameter int QW1    = 4,
  parameter int IW2    = 4,
  parameter int QW2    = 4,
  parameter int EXP_IW = IW1 + IW2,
  parameter int EXP_QW = QW1 + QW2
) (
  input  logic [IW1+QW1-1:0]         a,
  input  logic [IW2+QW2-1:0]         b,
  output logic [IW1+IW2+QW1+QW2-1:0] p
);

  localparam int PIW = IW1 + IW2;
  localparam int PQW = QW1 + QW2;
  localparam int PW  = PIW + PQW;

  generate
    if (PIW != EXP_IW || PQW != EXP_QW) begin : g_width_err
      $error("sfp_mult_full output format does not match the requested product format");
    end
  endgenerate

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;

  assign a_ext = PW'($signed(a));
  assign b_ext = PW'($signed(b));
  assign p     = a_ext * b_ext;

endmodule

// File: rtl/sfp_rr_arbiter.sv
// Round-robin arbiter: one-hot grant from the current pointer, pointer moves
// past the granted lane only when the grant is actually taken.
module sfp_rr_arbiter
  import fp_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic                  advance,
  output logic [N-1:0]          grant,
  output logic [id_w(N)-1:0]    grant_id
);

  localparam int IDW = id_w(N);

  logic [IDW-1:0] ptr;

  assign grant_id = IDW'(rr_next(4'(ptr), 16'(req), N));
  assign grant    = (|req) ? (N'(1) << grant_id) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/sfp_mult_arb.sv
// N requesters share one pipelined sfp multiplier; a round-robin arbiter takes
// one operand pair per cycle and products leave in order, tagged by lane.
module sfp_mult_arb
  import fp_sched_pkg::*;
#(
  parameter int N   = 4,
  parameter int IW1 = 4,
  parameter int QW1 = 4,
  parameter int IW2 = 4,
  parameter int QW2 = 4,
  parameter int LAT = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N-1:0]                   req_valid,
  output logic [N-1:0]                   req_ready,
  input  logic [N*(IW1+QW1)-1:0]         req_a,
  input  logic [N*(IW2+QW2)-1:0]         req_b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [id_w(N)-1:0]             out_id,
  output logic [IW1+IW2+QW1+QW2-1:0]     out_val
);

  localparam int W1  = IW1 + QW1;
  localparam int W2  = IW2 + QW2;
  localparam int PW  = W1 + W2;
  localparam int IDW = id_w(N);

  generate
    if (LAT < 1 || LAT > MAX_LAT || N < 2 || N > MAX_N) begin : g_param_err
      $error("sfp_mult_arb: LAT must be 1..4 and N must be 2..16");
    end
  endgenerate

  logic           stall;
  logic           advance;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;

  // A stalled output freezes the whole pipe, so nothing may be accepted.
  assign stall     = out_valid & ~out_ready;
  assign advance   = (|grant) & ~stall & ~rst;
  assign req_ready = grant & {N{~stall & ~rst}};

  sfp_rr_arbiter #(.N(N)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      (req_valid),
    .advance  (advance),
    .grant    (grant),
    .grant_id (grant_id)
  );

  logic           s0_v;
  logic [W1-1:0]  s0_a;
  logic [W2-1:0]  s0_b;
  logic [IDW-1:0] s0_id;
  logic [PW-1:0]  mult_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_v  <= 1'b0;
      s0_a  <= '0;
      s0_b  <= '0;
      s0_id <= '0;
    end else if (!stall) begin
      s0_v  <= advance;
      s0_a  <= req_a[grant_id*W1 +: W1];
      s0_b  <= req_b[grant_id*W2 +: W2];
      s0_id <= grant_id;
    end
  end

  sfp_mult_full #(
    .IW1    (IW1),
    .QW1    (QW1),
    .IW2    (IW2),
    .QW2    (QW2),
    .EXP_IW (IW1 + IW2),
    .EXP_QW (QW1 + QW2)
  ) u_mult (
    .a (s0_a),
    .b (s0_b),
    .p (mult_p)
  );

  generate
    if (LAT == 1) begin : g_lat1
      assign out_valid = s0_v;
      assign out_id    = s0_id;
      assign out_val   = mult_p;
    end else begin : g_latn
      logic           v_q  [LAT-1];
      logic [IDW-1:0] id_q [LAT-1];
      logic [PW-1:0]  p_q  [LAT-1];

      // Bubbles ride through as valid=0 so a gap never blocks later products.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < LAT - 1; k++) begin
            v_q[k]  <= 1'b0;
            id_q[k] <= '0;
            p_q[k]  <= '0;
          end
        end else if (!stall) begin
          v_q[0]  <= s0_v;
          id_q[0] <= s0_id;
          p_q[0]  <= mult_p;
          for (int k = 1; k < LAT - 1; k++) begin
            v_q[k]  <= v_q[k-1];
            id_q[k] <= id_q[k-1];
            p_q[k]  <= p_q[k-1];
          end
        end
      end

      assign out_valid = v_q[LAT-2];
      assign out_id    = id_q[LAT-2];
      assign out_val   = p_q[LAT-2];
    end
  endgenerate

endmodule
